// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory read/write arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int unsigned NUM_REQ           = 2;
  localparam int unsigned RAM_WORDS_DEFAULT = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant; the pointer moves only when the served request completes.
module rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               update,
  input  logic               served,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_id
);

  logic prio;

  // prio names the requester that wins a tie: the one not served last.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~served;
    end
  end

  always_comb begin
    grant    = '0;
    grant_id = prio;
    if (valid[prio]) begin
      grant[prio] = 1'b1;
      grant_id    = prio;
    end else if (valid[~prio]) begin
      grant[~prio] = 1'b1;
      grant_id     = ~prio;
    end
  end

endmodule

// File: rtl/mem_rw_arbiter.sv
// Arbitrates two requesters onto a single-port RAM: IDLE -> ACCESS -> RESP per operation.
// Optional index range checking is enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
module mem_rw_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_wen,
  input  logic [127:0] req_index,
  input  logic [127:0] req_wdata,
  input  logic [127:0] req_wmask,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [63:0]  resp_rdata,
  output logic         resp_err,
  output logic         r_enable,
  output logic         w_enable,
  output logic [63:0]  r_index,
  output logic [63:0]  w_index,
  input  logic [63:0]  r_data,
  output logic [63:0]  w_data,
  output logic [63:0]  w_mask
);

  state_t      state, state_nxt;
  logic [1:0]  grant;
  logic        grant_id;
  logic        accept;
  logic        handshake;
  logic [63:0] sel_index;
  logic        lat_wen;
  logic        lat_id;
  logic [63:0] lat_index;
  logic [63:0] lat_wdata;
  logic [63:0] lat_wmask;
  logic [63:0] rdata_q;

  rr_arbiter u_rr (
    .clock    (clock),
    .reset    (reset),
    .valid    (req_valid),
    .update   (handshake),
    .served   (lat_id),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_index = req_index[{grant_id, 6'd0} +: 64];
  assign accept    = !reset && (state == ST_IDLE) && (|req_valid);
  assign handshake = !reset && (state == ST_RESP) && resp_ready[lat_id];

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic oob;
  logic err_q;

  assign oob = sel_index >= 64'(RAM_WORDS);

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= oob;
    end
  end

  assign resp_err = !reset && (state == ST_RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      lat_wen   <= 1'b0;
      lat_id    <= 1'b0;
      lat_index <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_wen   <= req_wen[grant_id];
        lat_id    <= grant_id;
        lat_index <= sel_index;
        lat_wdata <= req_wdata[{grant_id, 6'd0} +: 64];
        lat_wmask <= req_wmask[{grant_id, 6'd0} +: 64];
        rdata_q   <= '0;
      end else if (state == ST_ACCESS && !lat_wen) begin
        rdata_q <= r_data;
      end
    end
  end

  // Every output is gated by reset so an operation caught mid-flight is dropped cleanly.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    r_enable   = 1'b0;
    w_enable   = 1'b0;
    r_index    = '0;
    w_index    = '0;
    w_data     = '0;
    w_mask     = '0;
    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          req_ready = grant;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
          if (accept) state_nxt = oob ? ST_RESP : ST_ACCESS;
`else
          if (accept) state_nxt = ST_ACCESS;
`endif
        end
        ST_ACCESS: begin
          if (lat_wen) begin
            w_enable = 1'b1;
            w_index  = lat_index;
            w_data   = lat_wdata;
            w_mask   = lat_wmask;
          end else begin
            r_enable = 1'b1;
            r_index  = lat_index;
          end
          state_nxt = ST_RESP;
        end
        ST_RESP: begin
          resp_valid[lat_id] = 1'b1;
          resp_rdata         = rdata_q;
          if (handshake) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Randomized and directed checks of mem_rw_arbiter against a transaction-level model.
module tb_mem_rw_arbiter;

  localparam int unsigned WORDS = 128;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_wen;
  logic [127:0] req_index;
  logic [127:0] req_wdata;
  logic [127:0] req_wmask;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [63:0]  resp_rdata;
  logic         resp_err;
  logic         r_enable;
  logic         w_enable;
  logic [63:0]  r_index;
  logic [63:0]  w_index;
  logic [63:0]  r_data;
  logic [63:0]  w_data;
  logic [63:0]  w_mask;

  mem_rw_arbiter #(.RAM_WORDS(WORDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_index  (req_index),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .r_enable   (r_enable),
    .w_enable   (w_enable),
    .r_index    (r_index),
    .w_index    (w_index),
    .r_data     (r_data),
    .w_data     (w_data),
    .w_mask     (w_mask)
  );

  always #5 clock = ~clock;

  // Backing RAM driven only by the DUT's RAM-side port.
  logic [63:0] ram [WORDS];
  assign r_data = r_enable ? ram[r_index[6:0]] : '0;
  always @(posedge clock) begin
    if (w_enable) ram[w_index[6:0]] <= (ram[w_index[6:0]] & ~w_mask) | (w_data & w_mask);
  end

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected memory plus the one outstanding transaction.
  logic [63:0] exp_mem [WORDS];
  bit          busy;
  int          stage;
  int          prefer;
  int          cur_id;
  bit          cur_wen;
  bit          cur_err;
  logic [63:0] cur_idx, cur_wd, cur_wm, exp_rdata;
  logic [63:0] last_rdata;
  bit          last_err;
  bit [1:0]    acc_flag;
  int          grants[$];

  task automatic cycle_chk();
    logic [1:0] exp_ready;
    int         win;
    bit         oob;
    @(negedge clock);
    if (reset) begin
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_resp_valid", resp_valid, 0);
      check_eq("rst_resp_rdata", resp_rdata, 0);
      check_eq("rst_resp_err", resp_err, 0);
      check_eq("rst_ram_en", {r_enable, w_enable}, 0);
      check_eq("rst_ram_bus", r_index | w_index | w_data | w_mask, 0);
      busy   = 0;
      prefer = 0;
    end else if (!busy) begin
      exp_ready = '0;
      win       = -1;
      if (req_valid[prefer]) win = prefer;
      else if (req_valid[1-prefer]) win = 1 - prefer;
      if (win >= 0) exp_ready[win] = 1'b1;
      check_eq("grant", req_ready, exp_ready);
      check_eq("idle_ram_en", {r_enable, w_enable}, 0);
      check_eq("idle_resp_valid", resp_valid, 0);
      if (win >= 0) begin
        busy    = 1;
        cur_id  = win;
        cur_wen = req_wen[win];
        cur_idx = req_index[win*64 +: 64];
        cur_wd  = req_wdata[win*64 +: 64];
        cur_wm  = req_wmask[win*64 +: 64];
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        oob = cur_idx >= 64'(WORDS);
`else
        oob = 0;
`endif
        cur_err   = oob;
        exp_rdata = '0;
        stage     = oob ? 2 : 1;
        acc_flag[win] = 1'b1;
        grants.push_back(win);
      end
    end else if (stage == 1) begin
      check_eq("acc_req_ready", req_ready, 0);
      check_eq("acc_resp_valid", resp_valid, 0);
      if (cur_wen) begin
        check_eq("wr_en", {r_enable, w_enable}, 2'b01);
        check_eq("wr_index", w_index, cur_idx);
        check_eq("wr_data", w_data, cur_wd);
        check_eq("wr_mask", w_mask, cur_wm);
        check_eq("wr_r_index", r_index, 0);
        exp_mem[cur_idx[6:0]] = (exp_mem[cur_idx[6:0]] & ~cur_wm) | (cur_wd & cur_wm);
      end else begin
        check_eq("rd_en", {r_enable, w_enable}, 2'b10);
        check_eq("rd_index", r_index, cur_idx);
        check_eq("rd_w_bus", w_index | w_data | w_mask, 0);
        exp_rdata = exp_mem[cur_idx[6:0]];
      end
      stage = 2;
    end else begin
      check_eq("resp_valid", resp_valid, 64'(1) << cur_id);
      check_eq("resp_rdata", resp_rdata, exp_rdata);
      check_eq("resp_err", resp_err, cur_err);
      check_eq("resp_req_ready", req_ready, 0);
      check_eq("resp_ram_en", {r_enable, w_enable}, 0);
      if (resp_ready[cur_id]) begin
        busy       = 0;
        prefer     = 1 - cur_id;
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) cycle_chk();
    check_eq("drain", busy, 0);
  endtask

  task automatic issue(input int id, input bit wen, input logic [63:0] idx,
                       input logic [63:0] wd, input logic [63:0] wm);
    req_valid[id]            = 1'b1;
    req_wen[id]              = wen;
    req_index[id*64 +: 64]   = idx;
    req_wdata[id*64 +: 64]   = wd;
    req_wmask[id*64 +: 64]   = wm;
    acc_flag[id]             = 1'b0;
    for (int i = 0; i < 20 && !acc_flag[id]; i++) cycle_chk();
    req_valid[id] = 1'b0;
    check_eq("accepted", acc_flag[id], 1);
    drain();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) cycle_chk();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i]     = '0;
      exp_mem[i] = '0;
    end
    busy = 0; stage = 0; prefer = 0; cur_id = 0; acc_flag = '0;
    req_valid = '0; req_wen = '0; req_index = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 2'b11;
    do_reset(2);

    // write then read
    issue(0, 1, 5, 64'hDEAD_BEEF, '1);
    issue(0, 0, 5, '0, '0);
    check_eq("wr_rd_data", last_rdata, 64'hDEAD_BEEF);
    check_eq("wr_rd_err", last_err, 0);

    // partial mask
    issue(1, 1, 7, 64'h1111_2222_3333_4444, '1);
    issue(0, 1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    issue(1, 0, 7, '0, '0);
    check_eq("mask_data", last_rdata, 64'h1111_2222_FFFF_FFFF);

    // contention from reset
    do_reset(1);
    grants.delete();
    req_wen = 2'b00;
    req_index = {64'd2, 64'd1};
    req_valid = 2'b11;
    for (int i = 0; i < 13; i++) cycle_chk();
    req_valid = 2'b00;
    drain();
    check_eq("cont_count", grants.size() >= 4, 1);
    if (grants.size() >= 4) begin
      check_eq("cont_g0", grants[0], 0);
      check_eq("cont_g1", grants[1], 1);
      check_eq("cont_g2", grants[2], 0);
      check_eq("cont_g3", grants[3], 1);
    end

    // backpressure, with a competing request and a stray resp_ready bit
    resp_ready = 2'b00;
    req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_index[127:64] = 64'd5;
    acc_flag = '0;
    for (int i = 0; i < 20 && !acc_flag[1]; i++) cycle_chk();
    check_eq("bp_accepted", acc_flag[1], 1);
    req_valid = 2'b01; req_wen[0] = 1'b0; req_index[63:0] = 64'd7;
    resp_ready = 2'b01;
    for (int i = 0; i < 6; i++) cycle_chk();
    check_eq("bp_still_busy", busy, 1);
    resp_ready = 2'b10;
    cycle_chk();
    check_eq("bp_rdata", last_rdata, 64'hDEAD_BEEF);
    resp_ready = 2'b11;
    acc_flag = '0;
    for (int i = 0; i < 20 && !acc_flag[0]; i++) cycle_chk();
    req_valid = 2'b00;
    check_eq("bp_next_accepted", acc_flag[0], 1);
    drain();

    // reset during ACCESS of a write
    issue(0, 1, 9, 64'h0909_0909_0909_0909, '1);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1;
    req_index[127:64] = 64'd9; req_wdata[127:64] = 64'hBAD0_BAD0_BAD0_BAD0; req_wmask[127:64] = '1;
    acc_flag = '0;
    for (int i = 0; i < 20 && !acc_flag[1]; i++) cycle_chk();
    check_eq("rst_wr_accepted", acc_flag[1], 1);
    req_valid = 2'b00;
    do_reset(1);
    grants.delete();
    req_wen = 2'b00;
    req_index = {64'd9, 64'd9};
    req_valid = 2'b11;
    for (int i = 0; i < 10 && grants.size() == 0; i++) cycle_chk();
    req_valid = 2'b00;
    check_eq("post_rst_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain();
    check_eq("post_rst_data", last_rdata, 64'h0909_0909_0909_0909);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    issue(0, 0, 128, '0, '0);
    check_eq("oob_err", last_err, 1);
    check_eq("oob_rdata", last_rdata, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_wen   = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        req_index[r*64 +: 64] = 64'($urandom_range(0, 15));
        req_wdata[r*64 +: 64] = {$urandom, $urandom};
        req_wmask[r*64 +: 64] = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
      end
      resp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      cycle_chk();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
